// File: rtl/dspi_instruction_arbiter.sv
// dspi_instruction_arbiter
//
// Round-robin merge of backward-path instructions from NUM_REQ local requesters
// onto the single registered backward instruction bus of a DSPI module chain.
// A granted RESET instruction opens a quiet window of GAP_CYCLES cycles. During
// that window nothing is accepted and IDLE is driven, so upstream modules can
// flush before new requests arrive.
//
// Optional feature (compile-time macro RESET_PRIORITY_EN):
//   defined   - in ARB, any valid requester presenting RESET wins over round-robin;
//               the lowest such index wins.
//   undefined - RESET competes in plain round-robin like any other type.
//
// Ports:
//   clk                       sole clock
//   rst                       synchronous active-high reset
//   req_Valid[NUM_REQ]        per-requester instruction valid
//   req_Ready[NUM_REQ]        per-requester accept (combinational); transfer on Valid&Ready
//   req_Instruction*          flattened per-requester payload, requester i at slice i
//   out_Instruction*          registered instruction driven to the chain
//   out_GrantIndex            requester whose instruction is on out_*
//   arb_Gap                   high while the post-RESET quiet window is active

module dspi_instruction_arbiter #(
  parameter int unsigned NUM_REQ                     = 4,
  parameter int unsigned STREAM_ID_WIDTH             = 4,
  parameter int unsigned CHANNEL_ID_WIDTH            = 10,
  parameter int unsigned INSTRUCTION_WIDTH           = 2,
  parameter int unsigned INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_IDLE    = INSTRUCTION_WIDTH'(0),
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_REQUEST = INSTRUCTION_WIDTH'(1),
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_REWIND  = INSTRUCTION_WIDTH'(2),
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_RESET   = INSTRUCTION_WIDTH'(3),
  parameter int unsigned GAP_CYCLES                  = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_REQ-1:0]                             req_Valid,
  output logic [NUM_REQ-1:0]                             req_Ready,
  input  logic [NUM_REQ*INSTRUCTION_WIDTH-1:0]           req_InstructionType,
  input  logic [NUM_REQ*STREAM_ID_WIDTH-1:0]             req_InstructionStreamID,
  input  logic [NUM_REQ*CHANNEL_ID_WIDTH-1:0]            req_InstructionChannelID,
  input  logic [NUM_REQ*INSTRUCTION_PARAMETER_WIDTH-1:0] req_InstructionParameter,
  output logic [INSTRUCTION_WIDTH-1:0]                   out_InstructionType,
  output logic [STREAM_ID_WIDTH-1:0]                     out_InstructionStreamID,
  output logic [CHANNEL_ID_WIDTH-1:0]                    out_InstructionChannelID,
  output logic [INSTRUCTION_PARAMETER_WIDTH-1:0]         out_InstructionParameter,
  output logic [$clog2(NUM_REQ)-1:0]                     out_GrantIndex,
  output logic                                           arb_Gap
);

  localparam int unsigned IdxW    = $clog2(NUM_REQ);
  localparam logic [7:0]  GapInit = 8'(GAP_CYCLES);

  typedef enum logic [0:0] {StArb, StGap} state_e;

  // Unpacked views of the flattened request payloads.
  logic [INSTRUCTION_WIDTH-1:0]           type_a  [NUM_REQ];
  logic [STREAM_ID_WIDTH-1:0]             sid_a   [NUM_REQ];
  logic [CHANNEL_ID_WIDTH-1:0]            cid_a   [NUM_REQ];
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] param_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign type_a[g]  = req_InstructionType[g*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
    assign sid_a[g]   = req_InstructionStreamID[g*STREAM_ID_WIDTH +: STREAM_ID_WIDTH];
    assign cid_a[g]   = req_InstructionChannelID[g*CHANNEL_ID_WIDTH +: CHANNEL_ID_WIDTH];
    assign param_a[g] =
        req_InstructionParameter[g*INSTRUCTION_PARAMETER_WIDTH +: INSTRUCTION_PARAMETER_WIDTH];
  end

  state_e                                 state_q;
  logic [IdxW-1:0]                        rr_ptr_q;
  logic [7:0]                             gap_cnt_q;
  logic [INSTRUCTION_WIDTH-1:0]           out_type_q;
  logic [STREAM_ID_WIDTH-1:0]             out_sid_q;
  logic [CHANNEL_ID_WIDTH-1:0]            out_cid_q;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] out_param_q;
  logic [IdxW-1:0]                        out_grant_q;

  logic            grant_valid;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] rr_ptr_d;
`ifdef RESET_PRIORITY_EN
  logic            rst_hit;
`endif

  // Winner selection: first valid index at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    winner      = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_valid && req_Valid[cand]) begin
        grant_valid = 1'b1;
        winner      = cand;
      end
    end
`ifdef RESET_PRIORITY_EN
    // A pending RESET overrides the round-robin choice; lowest index wins.
    rst_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'(i);
      if (!rst_hit && req_Valid[cand] && (type_a[cand] == INSTRUCTION_CMD_RESET)) begin
        rst_hit = 1'b1;
        winner  = cand;
      end
    end
`endif
  end

  assign rr_ptr_d = IdxW'((32'(winner) + 32'd1) % NUM_REQ);

  // Nothing is accepted while rst is high, so no instruction can be lost in the reset cycle.
  always_comb begin
    req_Ready = '0;
    if (!rst && (state_q == StArb) && grant_valid) begin
      req_Ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StArb;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      out_type_q  <= INSTRUCTION_CMD_IDLE;
      out_sid_q   <= '0;
      out_cid_q   <= '0;
      out_param_q <= '0;
      out_grant_q <= '0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (grant_valid) begin
            out_type_q  <= type_a[winner];
            out_sid_q   <= sid_a[winner];
            out_cid_q   <= cid_a[winner];
            out_param_q <= param_a[winner];
            out_grant_q <= winner;
            rr_ptr_q    <= rr_ptr_d;
            if ((type_a[winner] == INSTRUCTION_CMD_RESET) && (GapInit != 8'd0)) begin
              gap_cnt_q <= GapInit;
              state_q   <= StGap;
            end
          end else begin
            out_type_q <= INSTRUCTION_CMD_IDLE;
          end
        end
        StGap: begin
          out_type_q <= INSTRUCTION_CMD_IDLE;
          // Leave on the cycle the counter reaches 1 so the window is exactly GAP_CYCLES long.
          if (gap_cnt_q <= 8'd1) begin
            gap_cnt_q <= '0;
            state_q   <= StArb;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign out_InstructionType      = out_type_q;
  assign out_InstructionStreamID  = out_sid_q;
  assign out_InstructionChannelID = out_cid_q;
  assign out_InstructionParameter = out_param_q;
  assign out_GrantIndex           = out_grant_q;
  assign arb_Gap                  = (state_q == StGap);

endmodule

// File: tb/tb_dspi_instruction_arbiter.sv
// Scoreboard bench for dspi_instruction_arbiter (NUM_REQ=4, GAP_CYCLES=2).
// The stimulus checks req_Ready/arb_Gap per cycle and pushes the expected bus
// record for every accepted instruction; the monitor pops and compares one
// record whenever a non-IDLE instruction appears on out_*.

module tb_dspi_instruction_arbiter;

  localparam int unsigned N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_Valid;
  logic [N-1:0]  req_Ready;
  logic [N*2-1:0]  req_InstructionType;
  logic [N*4-1:0]  req_InstructionStreamID;
  logic [N*10-1:0] req_InstructionChannelID;
  logic [N*16-1:0] req_InstructionParameter;
  logic [1:0]    out_InstructionType;
  logic [3:0]    out_InstructionStreamID;
  logic [9:0]    out_InstructionChannelID;
  logic [15:0]   out_InstructionParameter;
  logic [1:0]    out_GrantIndex;
  logic          arb_Gap;

  logic [1:0]  tt [N];
  logic [3:0]  ts [N];
  logic [9:0]  tc [N];
  logic [15:0] tp [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_InstructionType[g*2 +: 2]        = tt[g];
    assign req_InstructionStreamID[g*4 +: 4]    = ts[g];
    assign req_InstructionChannelID[g*10 +: 10] = tc[g];
    assign req_InstructionParameter[g*16 +: 16] = tp[g];
  end

  dspi_instruction_arbiter #(
    .NUM_REQ                    (N),
    .STREAM_ID_WIDTH            (4),
    .CHANNEL_ID_WIDTH           (10),
    .INSTRUCTION_WIDTH          (2),
    .INSTRUCTION_PARAMETER_WIDTH(16),
    .GAP_CYCLES                 (2)
  ) u_dut (
    .clk                     (clk),
    .rst                     (rst),
    .req_Valid               (req_Valid),
    .req_Ready               (req_Ready),
    .req_InstructionType     (req_InstructionType),
    .req_InstructionStreamID (req_InstructionStreamID),
    .req_InstructionChannelID(req_InstructionChannelID),
    .req_InstructionParameter(req_InstructionParameter),
    .out_InstructionType     (out_InstructionType),
    .out_InstructionStreamID (out_InstructionStreamID),
    .out_InstructionChannelID(out_InstructionChannelID),
    .out_InstructionParameter(out_InstructionParameter),
    .out_GrantIndex          (out_GrantIndex),
    .arb_Gap                 (arb_Gap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] mk(input logic [1:0] t, input logic [3:0] s,
                                     input logic [9:0] c, input logic [15:0] p,
                                     input logic [1:0] g);
    return {t, s, c, p, g};
  endfunction

  // Monitor: every non-IDLE instruction on the bus must match the next expected record.
  always @(negedge clk) begin
    if (out_InstructionType != 2'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'({out_InstructionType, out_InstructionStreamID,
            out_InstructionChannelID, out_InstructionParameter, out_GrantIndex}), 64'd0);
      end else begin
        chk("bus_record", 64'({out_InstructionType, out_InstructionStreamID,
            out_InstructionChannelID, out_InstructionParameter, out_GrantIndex}),
            64'(exp_q.pop_front()));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_Valid = '0;
    for (int i = 0; i < N; i++) begin
      tt[i] = 2'd1;
      ts[i] = 4'(i);
      tc[i] = 10'(100 + i);
      tp[i] = 16'(16'h100 + i);
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset values, then idle with no requests.
    @(negedge clk);
    chk("rst_type", 64'(out_InstructionType), 64'd0);
    chk("rst_sid", 64'(out_InstructionStreamID), 64'd0);
    chk("rst_cid", 64'(out_InstructionChannelID), 64'd0);
    chk("rst_param", 64'(out_InstructionParameter), 64'd0);
    chk("rst_grant", 64'(out_GrantIndex), 64'd0);
    chk("rst_ready", 64'(req_Ready), 64'd0);
    chk("rst_gap", 64'(arb_Gap), 64'd0);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      @(negedge clk);
      chk("idle_type", 64'(out_InstructionType), 64'd0);
      chk("idle_ready", 64'(req_Ready), 64'd0);
    end

    // Fairness: all four valid, grants must rotate 0,1,2,3,0,...
    next_cycle();
    req_Valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("fair_ready", 64'(req_Ready), 64'(4'b0001 << (c % 4)));
      exp_q.push_back(mk(2'd1, 4'(c % 4), 10'(100 + c % 4), 16'(16'h100 + c % 4), 2'(c % 4)));
      next_cycle();
    end
    req_Valid = '0;

    // Single requester streaming back-to-back (rr_ptr is 0 here).
    for (int k = 0; k < 6; k++) begin
      tp[2] = 16'(10 + k);
      req_Valid = 4'b0100;
      @(negedge clk);
      chk("stream_ready", 64'(req_Ready), 64'b0100);
      exp_q.push_back(mk(2'd1, 4'd2, 10'd102, 16'(10 + k), 2'd2));
      next_cycle();
    end
    req_Valid = '0;

    // One grant to req0 moves rr_ptr from 3 to 1.
    req_Valid = 4'b0001;
    @(negedge clk);
    chk("pre_gap_ready", 64'(req_Ready), 64'b0001);
    exp_q.push_back(mk(2'd1, 4'd0, 10'd100, 16'h0100, 2'd0));
    next_cycle();

    // RESET gap: req1 RESET at t with req3 also valid.
    tt[1] = 2'd3; tp[1] = 16'hAAAA; tp[3] = 16'h3333;
    req_Valid = 4'b1010;
    @(negedge clk);
    chk("gap_t_ready", 64'(req_Ready), 64'b0010);
    chk("gap_t_gap", 64'(arb_Gap), 64'd0);
    exp_q.push_back(mk(2'd3, 4'd1, 10'd101, 16'hAAAA, 2'd1));
    next_cycle();
    req_Valid = 4'b1000;
    @(negedge clk);
    chk("gap_t1_gap", 64'(arb_Gap), 64'd1);
    chk("gap_t1_ready", 64'(req_Ready), 64'd0);
    chk("gap_t1_type", 64'(out_InstructionType), 64'd3);
    next_cycle();
    @(negedge clk);
    chk("gap_t2_gap", 64'(arb_Gap), 64'd1);
    chk("gap_t2_ready", 64'(req_Ready), 64'd0);
    chk("gap_t2_type", 64'(out_InstructionType), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("gap_t3_gap", 64'(arb_Gap), 64'd0);
    chk("gap_t3_ready", 64'(req_Ready), 64'b1000);
    chk("gap_t3_type", 64'(out_InstructionType), 64'd0);
    exp_q.push_back(mk(2'd1, 4'd3, 10'd103, 16'h3333, 2'd3));
    next_cycle();
    req_Valid = '0;
    @(negedge clk);
    chk("gap_t4_type", 64'(out_InstructionType), 64'd1);
    next_cycle();

    // Reset priority: rr_ptr=0, req0 REQUEST and req3 RESET both valid.
    tt[1] = 2'd1; tt[0] = 2'd1; tp[0] = 16'h0101; tt[3] = 2'd3; tp[3] = 16'h3030;
    req_Valid = 4'b1001;
`ifdef RESET_PRIORITY_EN
    @(negedge clk);
    chk("prio_first_ready", 64'(req_Ready), 64'b1000);
    exp_q.push_back(mk(2'd3, 4'd3, 10'd103, 16'h3030, 2'd3));
    next_cycle();
    req_Valid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("prio_gap_ready", 64'(req_Ready), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("prio_second_ready", 64'(req_Ready), 64'b0001);
    exp_q.push_back(mk(2'd1, 4'd0, 10'd100, 16'h0101, 2'd0));
    next_cycle();
    req_Valid = '0;
`else
    @(negedge clk);
    chk("prio_first_ready", 64'(req_Ready), 64'b0001);
    exp_q.push_back(mk(2'd1, 4'd0, 10'd100, 16'h0101, 2'd0));
    next_cycle();
    req_Valid = 4'b1000;
    @(negedge clk);
    chk("prio_second_ready", 64'(req_Ready), 64'b1000);
    exp_q.push_back(mk(2'd3, 4'd3, 10'd103, 16'h3030, 2'd3));
    next_cycle();
    req_Valid = '0;
`endif
    tt[3] = 2'd1;
    for (int c = 0; c < 4; c++) next_cycle();

    // Reset in the middle of a gap.
    tt[1] = 2'd3; tp[1] = 16'hBBBB; tt[2] = 2'd1; tp[2] = 16'h2222;
    req_Valid = 4'b0110;
    @(negedge clk);
    chk("mid_t_ready", 64'(req_Ready), 64'b0010);
    exp_q.push_back(mk(2'd3, 4'd1, 10'd101, 16'hBBBB, 2'd1));
    next_cycle();
    req_Valid = 4'b0100;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_t1_gap", 64'(arb_Gap), 64'd1);
    chk("mid_t1_ready", 64'(req_Ready), 64'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_t2_gap", 64'(arb_Gap), 64'd0);
    chk("mid_t2_type", 64'(out_InstructionType), 64'd0);
    chk("mid_t2_grant", 64'(out_GrantIndex), 64'd0);
    chk("mid_t2_ready", 64'(req_Ready), 64'b0100);
    exp_q.push_back(mk(2'd1, 4'd2, 10'd102, 16'h2222, 2'd2));
    next_cycle();
    req_Valid = '0;

    for (int c = 0; c < 4; c++) next_cycle();
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dspi_instruction_arbiter.md
# dspi_instruction_arbiter

Round-robin arbiter that merges backward-path instructions from up to NUM_REQ local requesters onto the single backward instruction bus of a DSPI module chain. Typical requesters are per-stream consumers, a memory-read engine and a control/flush unit. The arbiter sits between these requesters and a module's `*_InstructionType/StreamID/ChannelID/Parameter` outputs. After every RESET instruction it enforces a programmable quiet gap so upstream modules can flush before new requests arrive.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- STREAM_ID_WIDTH, 4, stream ID width
- CHANNEL_ID_WIDTH, 10, channel ID width
- INSTRUCTION_WIDTH, 2, instruction type width
- INSTRUCTION_PARAMETER_WIDTH, 16, parameter width
- INSTRUCTION_CMD_IDLE / _REQUEST / _REWIND / _RESET, 2'd0 / 2'd1 / 2'd2 / 2'd3, type encodings
- GAP_CYCLES, 2, forced IDLE cycles after an issued RESET (0..255; 0 = no gap)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- req_Valid  in  NUM_REQ  per-requester instruction valid
- req_Ready  out  NUM_REQ  per-requester accept; transfer when Valid&Ready
- req_InstructionType  in  NUM_REQ*INSTRUCTION_WIDTH  flattened; requester i at slice i
- req_InstructionStreamID  in  NUM_REQ*STREAM_ID_WIDTH  flattened
- req_InstructionChannelID  in  NUM_REQ*CHANNEL_ID_WIDTH  flattened
- req_InstructionParameter  in  NUM_REQ*INSTRUCTION_PARAMETER_WIDTH  flattened
- out_InstructionType  out  INSTRUCTION_WIDTH  registered instruction to chain
- out_InstructionStreamID  out  STREAM_ID_WIDTH  registered
- out_InstructionChannelID  out  CHANNEL_ID_WIDTH  registered
- out_InstructionParameter  out  INSTRUCTION_PARAMETER_WIDTH  registered
- out_GrantIndex  out  clog2(NUM_REQ)  index of requester whose instruction is on out_*
- arb_Gap  out  1  high while in GAP state

## Operation
- FSM: ARB, GAP.
- ARB: if any req_Valid, grant exactly one requester. The winner is the first valid index at or after rr_ptr, wrapping modulo NUM_REQ. req_Ready[winner]=1, all others 0. Payload is registered to out_*. rr_ptr <= (winner+1) mod NUM_REQ.
- ARB with no valid: out_InstructionType <= IDLE; other out_* and rr_ptr hold.
- A granted instruction of type RESET with GAP_CYCLES>0: gap_cnt <= GAP_CYCLES, go to GAP.
- GAP: all req_Ready=0, out_InstructionType=IDLE. gap_cnt decrements each cycle; return to ARB on the cycle gap_cnt reaches 1. The next grant is possible on the first ARB cycle.
- A granted IDLE-type instruction is consumed and issued as IDLE. It counts as a grant, so rr_ptr advances.
- No backpressure exists on the output: one instruction per cycle maximum, never dropped once Ready is given.
- Requester contract: payload stable while Valid and not Ready. Valid is never withdrawn before acceptance.

## Timing
- req_Ready is combinational from req_Valid, rr_ptr and FSM state.
- out_* update 1 cycle after the Valid&Ready cycle.
- Sustained throughput is 1 instruction/cycle, including back-to-back from the same requester when it is the only valid one.
- Reset values: out_InstructionType=IDLE, out_InstructionStreamID=0, out_InstructionChannelID=0, out_InstructionParameter=0, out_GrantIndex=0, req_Ready=0, arb_Gap=0, rr_ptr=0, FSM=ARB, gap_cnt=0.
- rst asserted mid-GAP or mid-grant: next cycle is the reset state. Any instruction accepted in the reset cycle is discarded.
- RESET granted with GAP_CYCLES=0: no GAP entry; ARB may grant next cycle.
- GAP window: with a RESET accepted at cycle t, arb_Gap is high at t+1..t+GAP_CYCLES and the next grant occurs at t+GAP_CYCLES+1.

## Configuration
- RESET_PRIORITY_EN defined: in ARB, any valid requester presenting RESET wins over round-robin. Lowest such index wins; rr_ptr <= winner+1.
- Not defined: RESET competes in plain round-robin like any other type.

## Test plan
- Reset then idle: all outputs at reset values; 5 cycles with no Valid -> out_InstructionType=0 every cycle, rr_ptr=0.
- Fairness: NUM_REQ=4, all four Valid continuously with REQUEST, StreamID=i -> grants 0,1,2,3,0,1,… ; out_InstructionStreamID sequence 0,1,2,3 one cycle after each Ready.
- Single requester streaming: only req 2 valid for 6 instructions, Parameter 10..15 -> Ready every cycle; out_Parameter 10..15 on consecutive cycles; out_GrantIndex=2.
- RESET gap: GAP_CYCLES=2, req 1 issues RESET at t while req 3 is valid -> arb_Gap high t+1,t+2; req 3 Ready at t+3; out shows RESET at t+1, IDLE at t+2, t+3, req 3 instruction at t+4.
- Reset priority, with RESET_PRIORITY_EN: rr_ptr=0, req0 REQUEST and req3 RESET valid -> req3 granted first. Without the macro -> req0 first.
- Reset mid-gap: rst at t+1 after a RESET grant with GAP_CYCLES=5 -> arb_Gap=0 and FSM=ARB at t+2; a valid requester is granted at t+2.
